// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order CDB completion, in-order commit from head.
// Optional feature: define ROB_FLUSH_EN to let the flush input clear the whole buffer in one edge.
package reorder_buffer_pkg;
  typedef struct packed {
    logic [1:0]  itype;
    logic [4:0]  destination;
    logic        jalr;
    logic        branch_pred;
    logic [3:0]  ras_pointer;
    logic [31:0] value;
    logic        branch_result;
    logic [3:0]  ROB_number;
  } ROB_entry_t;

  typedef struct packed {
    logic [3:0]  dest_ROB_entry;
    logic [31:0] result;
    logic        branch_result;
    logic        load_step1;
    logic        from_commit;
  } CDB_packet_t;
endpackage

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         alloc_valid,
  input  ROB_entry_t   alloc_entry,
  output logic         alloc_ready,
  output logic [3:0]   alloc_rob,
  input  logic         cdb_valid,
  input  CDB_packet_t  cdb_packet,
  input  logic         rd_en,
  output ROB_entry_t   head,
  output logic         rob_head_ready,
  output logic         empty,
  output logic         full,
  output logic [IDX_W:0] count,
  input  logic         flush
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  ROB_entry_t       mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready;
  logic [IDX_W-1:0] head_ptr;
  logic [IDX_W-1:0] tail_ptr;
  logic [IDX_W:0]   count_q;
  logic [IDX_W-1:0] dest_idx;
  logic             do_alloc;
  logic             do_deq;
  logic             do_wb;
  logic             do_flush;

`ifdef ROB_FLUSH_EN
  assign do_flush = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign do_flush     = 1'b0;
`endif

  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign alloc_ready = ~full;
  assign alloc_rob   = 4'(tail_ptr);

  assign do_alloc = alloc_valid & ~full;
  assign do_deq   = rd_en & ~empty;
  assign dest_idx = cdb_packet.dest_ROB_entry[IDX_W-1:0];
  // Dequeue wins over a same-cycle CDB write to the head entry.
  assign do_wb    = cdb_valid & ~cdb_packet.from_commit & ~cdb_packet.load_step1
                  & valid[dest_idx] & ~(do_deq & (dest_idx == head_ptr));

  // Invalid slots read as zero so the head is clean after reset or dequeue.
  assign head           = valid[head_ptr] ? mem[head_ptr] : '0;
  assign rob_head_ready = valid[head_ptr] & ready[head_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
      valid    <= '0;
      ready    <= '0;
    end else if (do_flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
      valid    <= '0;
      ready    <= '0;
    end else begin
      if (do_alloc) begin
        valid[tail_ptr] <= 1'b1;
        ready[tail_ptr] <= (alloc_entry.itype == 2'b01);
        tail_ptr        <= tail_ptr + 1'b1;
      end
      if (do_wb) ready[dest_idx] <= 1'b1;
      if (do_deq) begin
        valid[head_ptr] <= 1'b0;
        ready[head_ptr] <= 1'b0;
        head_ptr        <= head_ptr + 1'b1;
      end
      unique case ({do_alloc, do_deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage carries no reset; visibility is governed by valid.
  always_ff @(posedge clk) begin
    if (!do_flush) begin
      if (do_alloc) begin
        mem[tail_ptr]            <= alloc_entry;
        mem[tail_ptr].ROB_number <= 4'(tail_ptr);
      end
      if (do_wb) begin
        if (mem[dest_idx].itype == 2'b00)
          mem[dest_idx].branch_result <= cdb_packet.branch_result;
        else
          mem[dest_idx].value <= cdb_packet.result;
      end
    end
  end

endmodule
